// File: rtl/mac_seq_acc.sv
`default_nettype none
// ============================================================================
//  Module      : mac_seq_acc
//  Description : Sequential dot-product stage. Accepts one signed operand pair
//                per valid/ready handshake and accumulates A*B over K pairs.
//                The completed sum is then held on a valid/ready output port
//                until the consumer takes it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N   operand width (signed two's complement)
//    K   pairs accumulated per output vector (K >= 1)
//  Derived
//    SW  = 2*N+K-1, accumulator / result width (mod 2^SW wrap)
//  Ports
//    clk          in   1      clock, all state on rising edge
//    rst          in   1      synchronous active-high reset
//    clr_i        in   1      abort the partial vector (ignored in DONE)
//    in_valid_i   in   1      operand pair valid
//    in_ready_o   out  1      stage accepts a pair this cycle
//    a_i, b_i     in   N      signed operands
//    out_valid_o  out  1      s_o holds a completed dot product
//    out_ready_i  in   1      downstream accepts s_o this cycle
//    s_o          out  SW     signed dot-product result
//    idx_o        out  IDXW   pairs accepted in the current vector
//  Build option
//    MAC_SEQ_RELU_EN  when defined, the registered result is max(sum,0),
//                     taken after SW-bit truncation. Ports and timing are
//                     unchanged.
// ============================================================================
module mac_seq_acc #(
  parameter int N = 8,
  parameter int K = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N-1:0]          a_i,
  input  logic [N-1:0]          b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [2*N+K-2:0]      s_o,
  output logic [((K > 1) ? $clog2(K) : 1)-1:0] idx_o
);

  localparam int SW   = 2 * N + K - 1;
  // A K==1 build still needs a one-bit index so the port has a legal width.
  localparam int IDXW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(K - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [SW-1:0]   acc_q,   acc_d;
  logic [SW-1:0]   s_q,     s_d;
  logic [IDXW-1:0] idx_q,   idx_d;

  logic signed [N-1:0]    a_s;
  logic signed [N-1:0]    b_s;
  logic signed [2*N-1:0]  prod_s;
  logic signed [SW-1:0]   prod_sw;
  logic [SW-1:0]          sum_w;
  logic [SW-1:0]          res_w;
  logic                   accept_w;
  logic                   last_w;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  assign a_s = a_i;
  assign b_s = b_i;

  // Full 2N-bit signed product; both operands are signed and the result is
  // sized to 2N, so no bits are lost.
  assign prod_s = a_s * b_s;

  // Size cast of a signed value sign-extends to SW bits.
  assign prod_sw = SW'(prod_s);

  // Adding at SW+1 bits and truncating to SW is the same as a plain SW-bit
  // modular add, so the carry beyond bit SW-1 is simply never formed.
  assign sum_w = acc_q + prod_sw;

`ifdef MAC_SEQ_RELU_EN
  // Clamp negative results to zero after the wrap has been applied.
  assign res_w = sum_w[SW-1] ? '0 : sum_w;
`else
  assign res_w = sum_w;
`endif

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  assign in_ready_o  = (state_q == ST_ACC);
  assign out_valid_o = (state_q == ST_DONE);

  // clr wins over a same-cycle pair, so the pair is not counted as accepted.
  assign accept_w = in_ready_o && in_valid_i && !clr_i;
  assign last_w   = (idx_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    s_d     = s_q;
    idx_d   = idx_q;

    case (state_q)
      ST_ACC: begin
        if (clr_i) begin
          acc_d = '0;
          idx_d = '0;
        end else if (accept_w) begin
          if (last_w) begin
            // Final pair: the result goes straight to the output register,
            // and the accumulator is cleared for the next vector.
            s_d     = res_w;
            acc_d   = '0;
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            acc_d = sum_w;
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      ST_DONE: begin
        // clr is deliberately not looked at here so a finished result
        // survives until the consumer takes it.
        if (out_ready_i) begin
          state_d = ST_ACC;
        end
      end

      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      s_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
    end
  end

  assign s_o   = s_q;
  assign idx_o = idx_q;

endmodule
`default_nettype wire
